// File: rtl/avg_enc_pkg.sv
// avg_enc_pkg
// Shared types and word-layout constants for the AVG display-list writer.
//   cmd_kind_t  : decoded drawing command kind presented by the game engine
//   wr_state_t  : writer FSM state
//   field consts: fixed filler/tag fields of the encoded AVG words
package avg_enc_pkg;

   typedef enum logic [2:0] {
      CK_VEC  = 3'd0,
      CK_CNTR = 3'd1,
      CK_STAT = 3'd2,
      CK_SCAL = 3'd3,
      CK_JMP  = 3'd4,
      CK_JSR  = 3'd5,
      CK_RTS  = 3'd6,
      CK_EOF  = 3'd7
   } cmd_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WR1       = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } wr_state_t;

   // STAT: 4 zero bits between intensity and opcode, bit 4 clear selects STAT
   localparam logic [3:0] STAT_PAD     = 4'h0;
   localparam logic       STAT_TAG     = 1'b0;
   // SCAL: bits [4:3] = 2'b10 select the scale register
   localparam logic [1:0] SCAL_TAG     = 2'b10;
   // Operand-free instructions (CNTR, RTS, HALT)
   localparam logic [7:0] OPERAND_NONE = 8'h00;
   localparam logic [4:0] LOW_NONE     = 5'h00;

   // Words emitted per command
   localparam logic [1:0] NW_ONE       = 2'd1;
   localparam logic [1:0] NW_TWO       = 2'd2;

endpackage

// File: rtl/avg_defines.vh
// avg_defines.vh
// AVG instruction opcodes, found in bits [7:5] of every instruction word.
// Shared by the display-list encoder (producer) and the AVG decoder (consumer).
`ifndef AVG_DEFINES_VH
`define AVG_DEFINES_VH

`define AVG_OP_VCTR  3'd0
`define AVG_OP_HALT  3'd1
`define AVG_OP_SVEC  3'd2
`define AVG_OP_STORE 3'd3
`define AVG_OP_CNTR  3'd4
`define AVG_OP_JSR   3'd5
`define AVG_OP_RTS   3'd6
`define AVG_OP_JMP   3'd7

`endif

// File: rtl/avg_word_encoder.sv
// avg_word_encoder
// Combinational translation of one decoded drawing command into AVG
// instruction words.
//   kind   in  : command kind
//   dx, dy in  : 13-bit raw vector deltas
//   z      in  : intensity (VEC uses [2:0], STAT uses all four bits)
//   color  in  : STAT colour
//   lin    in  : SCAL linear scale
//   bin    in  : SCAL binary scale
//   addr   in  : JMP/JSR absolute word address
//   w0     out : first (or only) word
//   w1     out : second VCTR word, zero otherwise
//   nwords out : 1 or 2
// Build option: AVG_ENC_SVEC_EN -- when defined, vectors whose deltas both
// fit in 5 bits are emitted as a single SVEC word instead of a 2-word VCTR.
`include "avg_defines.vh"

module avg_word_encoder
   import avg_enc_pkg::*;
(
   input  cmd_kind_t   kind,
   input  logic [12:0] dx,
   input  logic [12:0] dy,
   input  logic [3:0]  z,
   input  logic [3:0]  color,
   input  logic [7:0]  lin,
   input  logic [2:0]  bin,
   input  logic [11:0] addr,
   output logic [15:0] w0,
   output logic [15:0] w1,
   output logic [1:0]  nwords
);

   logic compact;

`ifdef AVG_ENC_SVEC_EN
   // Upper delta bits all clear: the vector is representable as SVEC
   assign compact = (dx[12:5] == 8'h00) && (dy[12:5] == 8'h00);
`else
   assign compact = 1'b0;
`endif

   always_comb begin
      w0     = 16'h0000;
      w1     = 16'h0000;
      nwords = NW_ONE;
      case (kind)
         CK_VEC: begin
            if (compact) begin
               w0 = {z[2:0], dx[4:0], `AVG_OP_SVEC, dy[4:0]};
            end else begin
               w0     = {dy[7:0], `AVG_OP_VCTR, dy[12:8]};
               w1     = {z[2:0], dx[12:8], dx[7:0]};
               nwords = NW_TWO;
            end
         end
         CK_CNTR: w0 = {OPERAND_NONE, `AVG_OP_CNTR, LOW_NONE};
         CK_STAT: w0 = {z[3:0], STAT_PAD, `AVG_OP_STORE, STAT_TAG, color[3:0]};
         CK_SCAL: w0 = {lin[7:0], `AVG_OP_STORE, SCAL_TAG, bin[2:0]};
         CK_JMP:  w0 = {addr[7:0], `AVG_OP_JMP, 1'b0, addr[11:8]};
         CK_JSR:  w0 = {addr[7:0], `AVG_OP_JSR, 1'b0, addr[11:8]};
         CK_RTS:  w0 = {OPERAND_NONE, `AVG_OP_RTS, LOW_NONE};
         CK_EOF:  w0 = {OPERAND_NONE, `AVG_OP_HALT, LOW_NONE};
         default: w0 = 16'h0000;
      endcase
   end

endmodule

// File: rtl/avg_dlist_writer.sv
// avg_dlist_writer
// Display-list writer: accepts decoded drawing commands over valid/ready,
// encodes them into AVG words and writes them into the back half of a
// double-buffered vector RAM. An end-of-frame command appends HALT and,
// once the AVG reports it has halted, swaps front and back halves.
//   BUF_WORDS   : words per buffer half (power of two, 2*BUF_WORDS <= 4096)
//   clk, rst_n  : clock, asynchronous active-low reset
//   cmd_*       : command handshake and fields
//   avg_halted  : AVG is stopped on HALT (level)
//   vram_*      : registered RAM write port
//   front_buf   : half currently executed by the AVG
//   swap_pulse  : one-cycle pulse at the buffer swap
//   overflow    : sticky, a command was dropped this frame
//   words_used  : write pointer within the back buffer
// Build option: AVG_ENC_SVEC_EN (short-vector compaction in the encoder).
module avg_dlist_writer
   import avg_enc_pkg::*;
#(
   parameter int BUF_WORDS = 2048
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  cmd_kind_t                   cmd_kind,
   input  logic [12:0]                 cmd_dx,
   input  logic [12:0]                 cmd_dy,
   input  logic [3:0]                  cmd_z,
   input  logic [3:0]                  cmd_color,
   input  logic [7:0]                  cmd_lin,
   input  logic [2:0]                  cmd_bin,
   input  logic [11:0]                 cmd_addr,
   input  logic                        avg_halted,
   output logic                        vram_we,
   output logic [11:0]                 vram_addr,
   output logic [15:0]                 vram_wdata,
   output logic                        front_buf,
   output logic                        swap_pulse,
   output logic                        overflow,
   output logic [$clog2(BUF_WORDS):0]  words_used
);

   localparam int PW = $clog2(BUF_WORDS) + 1;
   // Highest pointer value a non-EOF command may reach; the final word of
   // each half is kept free so HALT always fits.
   localparam logic [PW:0] LIMIT = (PW+1)'(BUF_WORDS - 1);

   wr_state_t    state_q,      state_d;
   logic         cmd_ready_q,  cmd_ready_d;
   logic         vram_we_q,    vram_we_d;
   logic [11:0]  vram_addr_q,  vram_addr_d;
   logic [15:0]  vram_wdata_q, vram_wdata_d;
   logic         front_buf_q,  front_buf_d;
   logic         swap_pulse_q, swap_pulse_d;
   logic         overflow_q,   overflow_d;
   logic [PW-1:0] used_q,      used_d;
   logic [15:0]  w1_q,         w1_d;

   logic [15:0]  enc_w0;
   logic [15:0]  enc_w1;
   logic [1:0]   enc_nwords;
   logic         accept;
   logic         fits;
   logic [PW:0]  need_sum;
   logic [11:0]  base_addr;
   logic [11:0]  wr_addr;

   avg_word_encoder u_enc (
      .kind   (cmd_kind),
      .dx     (cmd_dx),
      .dy     (cmd_dy),
      .z      (cmd_z),
      .color  (cmd_color),
      .lin    (cmd_lin),
      .bin    (cmd_bin),
      .addr   (cmd_addr),
      .w0     (enc_w0),
      .w1     (enc_w1),
      .nwords (enc_nwords)
   );

   assign accept    = cmd_valid && cmd_ready_q;
   // Back buffer is the half the AVG is not executing
   assign base_addr = front_buf_q ? 12'd0 : 12'(BUF_WORDS);
   assign wr_addr   = base_addr + 12'(used_q);
   assign need_sum  = {1'b0, used_q} + (PW+1)'(enc_nwords);
   assign fits      = (need_sum <= LIMIT);

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      vram_we_d    = 1'b0;
      vram_addr_d  = vram_addr_q;
      vram_wdata_d = vram_wdata_q;
      front_buf_d  = front_buf_q;
      swap_pulse_d = 1'b0;
      overflow_d   = overflow_q;
      used_d       = used_q;
      w1_d         = w1_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_kind == CK_EOF) begin
                  // HALT always has room thanks to the reserved last word
                  vram_we_d    = 1'b1;
                  vram_addr_d  = wr_addr;
                  vram_wdata_d = enc_w0;
                  used_d       = used_q + 1'b1;
                  state_d      = ST_WAIT_SWAP;
                  cmd_ready_d  = 1'b0;
               end else if (fits) begin
                  vram_we_d    = 1'b1;
                  vram_addr_d  = wr_addr;
                  vram_wdata_d = enc_w0;
                  used_d       = used_q + 1'b1;
                  if (enc_nwords == NW_TWO) begin
                     // Park the second VCTR word; it goes out next cycle
                     w1_d        = enc_w1;
                     state_d     = ST_WR1;
                     cmd_ready_d = 1'b0;
                  end
               end else begin
                  // Handshake still completes; the command is discarded
                  overflow_d = 1'b1;
               end
            end
         end
         ST_WR1: begin
            vram_we_d    = 1'b1;
            vram_addr_d  = wr_addr;
            vram_wdata_d = w1_q;
            used_d       = used_q + 1'b1;
            state_d      = ST_IDLE;
            cmd_ready_d  = 1'b1;
         end
         ST_WAIT_SWAP: begin
            if (avg_halted) begin
               front_buf_d  = ~front_buf_q;
               swap_pulse_d = 1'b1;
               used_d       = '0;
               overflow_d   = 1'b0;
               state_d      = ST_IDLE;
               cmd_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cmd_ready_q  <= 1'b1;
         vram_we_q    <= 1'b0;
         vram_addr_q  <= 12'd0;
         vram_wdata_q <= 16'h0000;
         front_buf_q  <= 1'b0;
         swap_pulse_q <= 1'b0;
         overflow_q   <= 1'b0;
         used_q       <= '0;
         w1_q         <= 16'h0000;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         vram_we_q    <= vram_we_d;
         vram_addr_q  <= vram_addr_d;
         vram_wdata_q <= vram_wdata_d;
         front_buf_q  <= front_buf_d;
         swap_pulse_q <= swap_pulse_d;
         overflow_q   <= overflow_d;
         used_q       <= used_d;
         w1_q         <= w1_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign vram_we    = vram_we_q;
   assign vram_addr  = vram_addr_q;
   assign vram_wdata = vram_wdata_q;
   assign front_buf  = front_buf_q;
   assign swap_pulse = swap_pulse_q;
   assign overflow   = overflow_q;
   assign words_used = used_q;

endmodule
